fir_sample_feeder: RTL and testbench

- Transmit-side driver for the time-multiplexed (folded) 28-tap FIR: accepts samples from an upstream valid/ready stream and buffers them in a small FIFO.
- Presents them on the FIR's din/en interface at exactly one new sample per fold period (FOLD clocks).
- en is held high continuously while streaming; din changes only on slot boundaries.
- Sits between the sample source (ADC capture / test pattern block) and the FIR input.

---
 rtl/fir_pkg.sv | 18 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/fir_sample_feeder.sv | 118 +++++++++++
 tb/tb_fir_sample_feeder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared constants and types for the folded 28-tap FIR and its sample feeder.
package fir_pkg;

  localparam int unsigned FIR_WIDTH = 16;
  localparam int unsigned FIR_TAPS  = 28;
  localparam int unsigned FIR_FOLD  = FIR_TAPS + 1;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } feeder_state_e;

  // Counter width for a modulo-n counter, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous reset, occupancy output and a combinational head read port.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    level_q, level_d;
  logic             do_push, do_pop;

  assign full_o  = (level_q == (PtrW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A full FIFO refuses pushes even when a pop frees an entry in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/fir_sample_feeder.sv
// Buffers upstream samples and presents one per fold period on the folded FIR's din/en inputs.
module fir_sample_feeder
  import fir_pkg::*;
#(
  parameter int unsigned WIDTH = FIR_WIDTH,
  parameter int unsigned FOLD  = FIR_FOLD,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     run,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [WIDTH-1:0]         s_data,
  output logic [WIDTH-1:0]         din,
  output logic                     en,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     underrun,
  output logic [15:0]              sample_cnt
);

  localparam int unsigned SlotW = cnt_width(FOLD);

  feeder_state_e    state_q, state_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             en_q, en_d;
  logic             underrun_q, underrun_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [15:0]      sample_cnt_q, sample_cnt_d;

  logic             fifo_pop;
  logic             fifo_full, fifo_empty;
  logic [WIDTH-1:0] fifo_rdata;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .push_i  (s_valid),
    .pop_i   (fifo_pop),
    .wdata_i (s_data),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign s_ready = !fifo_full;

  always_comb begin
    state_d      = state_q;
    din_d        = din_q;
    en_d         = 1'b0;
    underrun_d   = 1'b0;
    slot_d       = slot_q;
    sample_cnt_d = sample_cnt_q;
    fifo_pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (run && !fifo_empty) begin
          fifo_pop     = 1'b1;
          din_d        = fifo_rdata;
          en_d         = 1'b1;
          slot_d       = '0;
          sample_cnt_d = sample_cnt_q + 16'd1;
          state_d      = StRun;
        end
      end
      StRun: begin
        en_d   = 1'b1;
        slot_d = slot_q + 1'b1;
        // run is only honoured on the last cycle of a slot so slots are never truncated.
        if (slot_q == SlotW'(FOLD - 1)) begin
          slot_d = '0;
          if (!run) begin
            en_d    = 1'b0;
            state_d = StIdle;
          end else if (!fifo_empty) begin
            fifo_pop     = 1'b1;
            din_d        = fifo_rdata;
            sample_cnt_d = sample_cnt_q + 16'd1;
          end else begin
            din_d        = '0;
            underrun_d   = 1'b1;
            sample_cnt_d = sample_cnt_q + 16'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      din_q        <= '0;
      en_q         <= 1'b0;
      underrun_q   <= 1'b0;
      slot_q       <= '0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      din_q        <= din_d;
      en_q         <= en_d;
      underrun_q   <= underrun_d;
      slot_q       <= slot_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign din        = din_q;
  assign en         = en_q;
  assign underrun   = underrun_q;
  assign sample_cnt = sample_cnt_q;

endmodule

// File: tb/tb_fir_sample_feeder.sv
// Directed bench: streaming, underrun, backpressure, stop, reset, FIFO and sample-counter wrap.
module tb_fir_sample_feeder;

  logic        clk;
  logic        rst;
  logic        run;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_data;
  logic [15:0] din;
  logic        en;
  logic [3:0]  fifo_level;
  logic        underrun;
  logic [15:0] sample_cnt;

  // Second instance with a one-clock fold so the 16-bit counter wraps quickly.
  logic        w_rst;
  logic        w_run;
  logic        w_valid;
  logic        w_ready;
  logic [15:0] w_data;
  logic [15:0] w_din;
  logic        w_en;
  logic [3:0]  w_level;
  logic        w_underrun;
  logic [15:0] w_cnt;

  int total;
  int bad;

  fir_sample_feeder #(
    .WIDTH (16),
    .FOLD  (29),
    .DEPTH (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .din        (din),
    .en         (en),
    .fifo_level (fifo_level),
    .underrun   (underrun),
    .sample_cnt (sample_cnt)
  );

  fir_sample_feeder #(
    .WIDTH (16),
    .FOLD  (1),
    .DEPTH (8)
  ) dut_wrap (
    .clk        (clk),
    .rst        (w_rst),
    .run        (w_run),
    .s_valid    (w_valid),
    .s_ready    (w_ready),
    .s_data     (w_data),
    .din        (w_din),
    .en         (w_en),
    .fifo_level (w_level),
    .underrun   (w_underrun),
    .sample_cnt (w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n cycles mid-slot: din steady, en high, no underrun.
  task automatic hold(input logic [15:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      chk("hold_din", {16'h0, din}, {16'h0, val});
      chk("hold_en", {31'h0, en}, 32'h1);
      chk("hold_underrun", {31'h0, underrun}, 32'h0);
    end
  endtask

  initial begin
    int n;
    total   = 0;
    bad     = 0;
    rst     = 1'b1;
    run     = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    w_rst   = 1'b1;
    w_run   = 1'b0;
    w_valid = 1'b0;
    w_data  = '0;

    step();
    step();
    chk("rst_en", {31'h0, en}, 32'h0);
    chk("rst_din", {16'h0, din}, 32'h0);
    chk("rst_level", {28'h0, fifo_level}, 32'h0);
    chk("rst_cnt", {16'h0, sample_cnt}, 32'h0);
    chk("rst_underrun", {31'h0, underrun}, 32'h0);
    chk("rst_ready", {31'h0, s_ready}, 32'h1);
    rst   = 1'b0;
    w_rst = 1'b0;

    // Basic stream.
    run     = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'h0001;
    step();
    chk("basic_lvl1", {28'h0, fifo_level}, 32'h1);
    chk("basic_en0", {31'h0, en}, 32'h0);
    s_data = 16'h0002;
    step();
    chk("basic_din1", {16'h0, din}, 32'h1);
    chk("basic_en1", {31'h0, en}, 32'h1);
    chk("basic_cnt1", {16'h0, sample_cnt}, 32'h1);
    s_data = 16'h0003;
    step();
    s_valid = 1'b0;
    chk("basic_lvl2", {28'h0, fifo_level}, 32'h2);
    hold(16'h0001, 27);
    step();
    chk("basic_din2", {16'h0, din}, 32'h2);
    chk("basic_cnt2", {16'h0, sample_cnt}, 32'h2);
    hold(16'h0002, 28);
    step();
    chk("basic_din3", {16'h0, din}, 32'h3);
    chk("basic_cnt3", {16'h0, sample_cnt}, 32'h3);
    chk("basic_lvl0", {28'h0, fifo_level}, 32'h0);

    // Underrun, then a single 0x7FFF followed by continuous zero-fill.
    hold(16'h0003, 28);
    step();
    chk("unf_din0", {16'h0, din}, 32'h0);
    chk("unf_pulse", {31'h0, underrun}, 32'h1);
    chk("unf_cnt4", {16'h0, sample_cnt}, 32'h4);
    s_valid = 1'b1;
    s_data  = 16'h7FFF;
    step();
    s_valid = 1'b0;
    chk("unf_pulse_end", {31'h0, underrun}, 32'h0);
    hold(16'h0000, 27);
    step();
    chk("unf_din7fff", {16'h0, din}, 32'h7FFF);
    chk("unf_cnt5", {16'h0, sample_cnt}, 32'h5);
    hold(16'h7FFF, 28);
    step();
    chk("unf2_din", {16'h0, din}, 32'h0);
    chk("unf2_pulse", {31'h0, underrun}, 32'h1);
    chk("unf2_cnt6", {16'h0, sample_cnt}, 32'h6);
    hold(16'h0000, 28);
    step();
    chk("unf3_pulse", {31'h0, underrun}, 32'h1);
    chk("unf3_cnt7", {16'h0, sample_cnt}, 32'h7);

    // Stop mid-slot: the slot finishes, then en drops and din holds.
    s_valid = 1'b1;
    s_data  = 16'h1234;
    step();
    s_data = 16'h5678;
    step();
    s_valid = 1'b0;
    chk("stop_lvl2", {28'h0, fifo_level}, 32'h2);
    hold(16'h0000, 26);
    step();
    chk("stop_din", {16'h0, din}, 32'h1234);
    chk("stop_cnt8", {16'h0, sample_cnt}, 32'h8);
    hold(16'h1234, 5);
    run = 1'b0;
    hold(16'h1234, 23);
    step();
    chk("stop_en0", {31'h0, en}, 32'h0);
    chk("stop_din_hold", {16'h0, din}, 32'h1234);
    chk("stop_lvl1", {28'h0, fifo_level}, 32'h1);
    chk("stop_cnt", {16'h0, sample_cnt}, 32'h8);
    step();
    chk("stop_idle_en", {31'h0, en}, 32'h0);
    chk("stop_idle_lvl", {28'h0, fifo_level}, 32'h1);

    // Reset mid-operation at slot 10 with four entries queued.
    run     = 1'b1;
    s_valid = 1'b1;
    s_data  = 16'hA001;
    step();
    chk("mrst_din", {16'h0, din}, 32'h5678);
    chk("mrst_cnt9", {16'h0, sample_cnt}, 32'h9);
    s_data = 16'hA002;
    step();
    s_data = 16'hA003;
    step();
    s_data = 16'hA004;
    step();
    s_valid = 1'b0;
    hold(16'h5678, 7);
    chk("mrst_lvl4", {28'h0, fifo_level}, 32'h4);
    rst = 1'b1;
    step();
    chk("mrst_en", {31'h0, en}, 32'h0);
    chk("mrst_din0", {16'h0, din}, 32'h0);
    chk("mrst_lvl0", {28'h0, fifo_level}, 32'h0);
    chk("mrst_cnt0", {16'h0, sample_cnt}, 32'h0);
    chk("mrst_ready", {31'h0, s_ready}, 32'h1);
    rst = 1'b0;
    run = 1'b0;
    step();
    chk("mrst_after_lvl", {28'h0, fifo_level}, 32'h0);
    chk("mrst_after_en", {31'h0, en}, 32'h0);

    // Backpressure: fill eight entries, ninth waits at the source.
    for (int i = 1; i <= 8; i++) begin
      s_valid = 1'b1;
      s_data  = 16'h0100 + 16'(i);
      step();
    end
    chk("bp_lvl8", {28'h0, fifo_level}, 32'h8);
    chk("bp_ready0", {31'h0, s_ready}, 32'h0);
    s_data = 16'h0109;
    step();
    chk("bp_lvl8_held", {28'h0, fifo_level}, 32'h8);
    chk("bp_ready0_held", {31'h0, s_ready}, 32'h0);
    run = 1'b1;
    step();
    chk("bp_din101", {16'h0, din}, 32'h0101);
    chk("bp_lvl7", {28'h0, fifo_level}, 32'h7);
    chk("bp_ready1", {31'h0, s_ready}, 32'h1);
    step();
    s_valid = 1'b0;
    chk("bp_lvl8_again", {28'h0, fifo_level}, 32'h8);
    for (int k = 2; k <= 9; k++) begin
      hold(16'h0100 + 16'(k - 1), (k == 2) ? 27 : 28);
      step();
      chk("bp_order", {16'h0, din}, 32'h0100 + k);
      chk("bp_cnt", {16'h0, sample_cnt}, k);
    end
    chk("bp_drained", {28'h0, fifo_level}, 32'h0);
    hold(16'h0109, 28);
    step();
    chk("bp_tail_zero", {16'h0, din}, 32'h0);
    chk("bp_tail_unf", {31'h0, underrun}, 32'h1);
    run = 1'b0;

    // One-clock fold: 20 push/pop pairs across the pointer wrap, then counter wrap.
    w_run = 1'b1;
    for (int i = 0; i < 20; i++) begin
      w_valid = 1'b1;
      w_data  = 16'h0200 + 16'(i);
      step();
      if (i == 0) begin
        chk("wr_first_lvl", {28'h0, w_level}, 32'h1);
        chk("wr_first_en", {31'h0, w_en}, 32'h0);
      end else begin
        chk("wr_pair_din", {16'h0, w_din}, 32'h0200 + i - 1);
        chk("wr_pair_lvl", {28'h0, w_level}, 32'h1);
      end
    end
    w_valid = 1'b0;
    step();
    chk("wr_last_din", {16'h0, w_din}, 32'h0213);
    chk("wr_last_lvl", {28'h0, w_level}, 32'h0);
    chk("wr_last_cnt", {16'h0, w_cnt}, 32'd20);
    step();
    chk("wr_zero_din", {16'h0, w_din}, 32'h0);
    chk("wr_zero_unf", {31'h0, w_underrun}, 32'h1);
    chk("wr_zero_cnt", {16'h0, w_cnt}, 32'd21);
    n = 0;
    while (w_cnt !== 16'hFFFF && n < 70000) begin
      step();
      n++;
    end
    chk("wrap_reach_ffff", {16'h0, w_cnt}, 32'hFFFF);
    step();
    chk("wrap_to_zero", {16'h0, w_cnt}, 32'h0);
    chk("wrap_unf", {31'h0, w_underrun}, 32'h1);
    step();
    chk("wrap_one", {16'h0, w_cnt}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
